// File: rtl/fc_pcs_pkg.sv
// Shared PCS constants for the 32b -> 66b receive gearbox.
package fc_pcs_pkg;

  localparam int GB_IN_W  = 32;
  localparam int GB_BLK_W = 66;
  localparam int GB_BUF_W = 98;
  localparam int GB_CNT_W = 7;

  localparam logic [GB_CNT_W-1:0] GB_OFS_MAX = GB_CNT_W'(GB_BLK_W - 1);

  // Slip offset counts bit positions inside one block, so it wraps at the block width.
  function automatic logic [GB_CNT_W-1:0] gb_ofs_inc(input logic [GB_CNT_W-1:0] ofs);
    return (ofs == GB_OFS_MAX) ? '0 : ofs + 1'b1;
  endfunction

endpackage

// File: rtl/gearbox_32_66.sv
// Receive gearbox: packs 32-bit words into 66-bit blocks, with single-bit slip
// requests from block sync moving the block boundary one bit later.
module gearbox_32_66
  import fc_pcs_pkg::*;
(
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [GB_IN_W-1:0]  RX_DATA,
  input  logic                RX_DATA_VLD,
  input  logic                BLK_SLIP,
  output logic [GB_BLK_W-1:0] GB_BLK,
  output logic                GB_BLK_ENA,
  output logic [6:0]          CSR_STAT_GB_BIT_OFS
);

  localparam logic [GB_CNT_W-1:0] IN_STEP   = GB_CNT_W'(GB_IN_W);
  localparam logic [GB_CNT_W-1:0] NEED_NORM = GB_CNT_W'(GB_BLK_W);
  localparam logic [GB_CNT_W-1:0] NEED_SLIP = GB_CNT_W'(GB_BLK_W + 1);

  // Bits at and above buf_cnt are kept zero so a new word can simply be OR-ed in.
  logic [GB_BUF_W-1:0] bit_buf;
  logic [GB_CNT_W-1:0] buf_cnt;
  logic                slip_pending;

  logic [GB_BUF_W-1:0] buf_app;
  logic [GB_BUF_W-1:0] buf_nxt;
  logic [GB_CNT_W-1:0] fill;
  logic [GB_CNT_W-1:0] need;
  logic [GB_CNT_W-1:0] cnt_nxt;
  logic [GB_BLK_W-1:0] window;
  logic                emit;

  always_comb begin
    buf_app = bit_buf;
    fill    = buf_cnt;
    if (RX_DATA_VLD) begin
      buf_app = bit_buf | ({{(GB_BUF_W-GB_IN_W){1'b0}}, RX_DATA} << buf_cnt);
      fill    = buf_cnt + IN_STEP;
    end
    need    = slip_pending ? NEED_SLIP : NEED_NORM;
    emit    = (fill >= need);
    // A pending slip drops the oldest bit, so the block starts one bit later.
    window  = slip_pending ? buf_app[GB_BLK_W:1] : buf_app[GB_BLK_W-1:0];
    buf_nxt = emit ? (buf_app >> need) : buf_app;
    cnt_nxt = emit ? (fill - need) : fill;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bit_buf             <= '0;
      buf_cnt             <= '0;
      slip_pending        <= 1'b0;
      GB_BLK              <= '0;
      GB_BLK_ENA          <= 1'b0;
      CSR_STAT_GB_BIT_OFS <= '0;
    end else begin
      bit_buf    <= buf_nxt;
      buf_cnt    <= cnt_nxt;
      GB_BLK_ENA <= emit;
      if (emit) begin
        GB_BLK <= window;
      end
      if (emit && slip_pending) begin
        CSR_STAT_GB_BIT_OFS <= gb_ofs_inc(CSR_STAT_GB_BIT_OFS);
      end
      // A slip request while one is already queued is dropped, not stacked.
      if (slip_pending) begin
        slip_pending <= !emit;
      end else begin
        slip_pending <= BLK_SLIP;
      end
    end
  end

endmodule
